// File: rtl/ser4_mux_sequencer_if.sv
// ----------------------------------------------------------------------------
// ser4_mux_sequencer_if
//   Bundles the word-input handshake, the four lanes and the serial slot
//   output of ser4_mux_sequencer.
//
//   Parameter
//     DATA_W   width of each lane I0..I3 and of O
//
//   Signals
//     I_VALID  upstream word valid
//     I_READY  sequencer can accept a word
//     I0..I3   lane data, sampled only on the input handshake
//     O        selected lane hold[S]
//     O_VALID  O is a valid slot
//     O_READY  downstream accepts the current slot
//     S        current select {S1,S0} (00->I0 .. 11->I3)
//     O_LAST   high on slot 3 of a word
//
//   Modports
//     master   word producer / slot consumer side
//     slave    the sequencer itself
// ----------------------------------------------------------------------------
interface ser4_mux_sequencer_if #(
    parameter int DATA_W = 1
) ();
    logic              I_VALID;
    logic              I_READY;
    logic [DATA_W-1:0] I0;
    logic [DATA_W-1:0] I1;
    logic [DATA_W-1:0] I2;
    logic [DATA_W-1:0] I3;
    logic [DATA_W-1:0] O;
    logic              O_VALID;
    logic              O_READY;
    logic [1:0]        S;
    logic              O_LAST;

    modport master (
        output I_VALID, I0, I1, I2, I3, O_READY,
        input  I_READY, O, O_VALID, S, O_LAST
    );

    modport slave (
        input  I_VALID, I0, I1, I2, I3, O_READY,
        output I_READY, O, O_VALID, S, O_LAST
    );
endinterface

// File: rtl/ser4_mux_sequencer.sv
// ----------------------------------------------------------------------------
// ser4_mux_sequencer
//   4:1 parallel-to-serial sequencer feeding a MUX4 select path. A 4-lane
//   word is captured on the input handshake and then presented one lane per
//   accepted output slot, with S carrying the matching MUX4 select.
//
//   Parameter
//     DATA_W   width of each lane and of O (default 1)
//
//   Ports
//     CLK      single clock, rising edge
//     CLEAR    asynchronous, active-high reset
//     bus      ser4_mux_sequencer_if.slave (I_VALID/I_READY, I0..I3,
//              O/O_VALID/O_READY, S, O_LAST)
//
//   Build option
//     SER4_MUX_SEQUENCER_PRELOAD_EN  when defined, a new word may be loaded
//     on the same edge as the last-slot transfer, giving gapless words.
//     When undefined, a word is only accepted in IDLE, so every word is
//     followed by at least one idle cycle.
// ----------------------------------------------------------------------------
module ser4_mux_sequencer #(
    parameter int DATA_W = 1
) (
    input logic                 CLK,
    input logic                 CLEAR,
    ser4_mux_sequencer_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] hold [4];

    logic in_hs;
    logic slot_xfer;
    logic last_xfer;

    assign slot_xfer = (state == SHIFT) && bus.O_READY;
    assign last_xfer = slot_xfer && (cnt == 2'd3);

`ifdef SER4_MUX_SEQUENCER_PRELOAD_EN
    // Ready on the last-slot transfer lets the next word replace the
    // current one without dropping O_VALID.
    assign bus.I_READY = (state == IDLE) || last_xfer;
`else
    assign bus.I_READY = (state == IDLE);
`endif

    assign in_hs = bus.I_VALID && bus.I_READY;

    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            hold[0] <= '0;
            hold[1] <= '0;
            hold[2] <= '0;
            hold[3] <= '0;
        end else begin
            if (in_hs) begin
                // Also covers the preload case: the load wins over the
                // last-slot return to IDLE.
                hold[0] <= bus.I0;
                hold[1] <= bus.I1;
                hold[2] <= bus.I2;
                hold[3] <= bus.I3;
                cnt     <= 2'd0;
                state   <= SHIFT;
            end else if (slot_xfer) begin
                if (cnt == 2'd3) begin
                    cnt   <= 2'd0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

    // Outputs are decoded straight from the registers.
    assign bus.S       = cnt;
    assign bus.O       = hold[cnt];
    assign bus.O_VALID = (state == SHIFT);
    assign bus.O_LAST  = (state == SHIFT) && (cnt == 2'd3);

endmodule
